// File: rtl/line_pkg.sv
// Shared types for the Bresenham line engine: coordinate/delta/error widths and FSM states.
package line_pkg;

    localparam int LINE_COORD_W = 11;

    typedef logic [LINE_COORD_W-1:0]        coord_t;
    typedef logic signed [LINE_COORD_W:0]   delta_t;
    typedef logic signed [LINE_COORD_W+1:0] err_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_SETUP,
        L_DRAW,
        L_DONE
    } line_state_e;

endpackage

// File: rtl/line_setup.sv
// Combinational line setup: steep detect, octant normalisation swaps, abs deltas, ystep, initial error.
module line_setup #(
    parameter int W = 11
) (
    input  logic [W-1:0]        x0,
    input  logic [W-1:0]        y0,
    input  logic [W-1:0]        x1,
    input  logic [W-1:0]        y1,
    output logic                steep,
    output logic [W-1:0]        maj0,
    output logic [W-1:0]        mnr0,
    output logic [W-1:0]        maj1,
    output logic signed [W:0]   dx,
    output logic signed [W:0]   dy,
    output logic                ystep_neg,
    output logic signed [W+1:0] err0
);

    logic [W-1:0] adx, ady;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W-1:0] mnr1, dmaj, dmnr;

    always_comb begin
        adx   = (x1 >= x0) ? x1 - x0 : x0 - x1;
        ady   = (y1 >= y0) ? y1 - y0 : y0 - y1;
        steep = ady > adx;

        a0 = steep ? y0 : x0;
        b0 = steep ? x0 : y0;
        a1 = steep ? y1 : x1;
        b1 = steep ? x1 : y1;

        // Always walk the major axis upwards from the smaller endpoint.
        if (a0 > a1) begin
            maj0 = a1;
            mnr0 = b1;
            maj1 = a0;
            mnr1 = b0;
        end else begin
            maj0 = a0;
            mnr0 = b0;
            maj1 = a1;
            mnr1 = b1;
        end

        dmaj      = maj1 - maj0;
        dmnr      = (mnr1 >= mnr0) ? mnr1 - mnr0 : mnr0 - mnr1;
        dx        = $signed({1'b0, dmaj});
        dy        = $signed({1'b0, dmnr});
        ystep_neg = !(mnr0 < mnr1);
        err0      = '0 - $signed({2'b00, dmaj >> 1});
    end

endmodule

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: one request in, one pixel per cycle out, level 'done' when finished.
// Optional LINE_PIXEL_STALL_EN adds a pixel_ready back-pressure input.
module bresenham_line_engine
    import line_pkg::*;
#(
    parameter int COORD_W = LINE_COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
`ifdef LINE_PIXEL_STALL_EN
    input  logic               pixel_ready,
`endif
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] ONE = 1;

    line_state_e state;

    logic [COORD_W-1:0]        ex0, ey0, ex1, ey1;
    logic                      steep_r, ystep_neg_r;
    logic [COORD_W-1:0]        maj, mnr, maj_end;
    logic signed [COORD_W:0]   dx_r, dy_r;
    logic signed [COORD_W+1:0] err;

    logic                      su_steep, su_neg;
    logic [COORD_W-1:0]        su_maj0, su_mnr0, su_maj1;
    logic signed [COORD_W:0]   su_dx, su_dy;
    logic signed [COORD_W+1:0] su_err0;

    line_setup #(.W(COORD_W)) u_setup (
        .x0        (ex0),
        .y0        (ey0),
        .x1        (ex1),
        .y1        (ey1),
        .steep     (su_steep),
        .maj0      (su_maj0),
        .mnr0      (su_mnr0),
        .maj1      (su_maj1),
        .dx        (su_dx),
        .dy        (su_dy),
        .ystep_neg (su_neg),
        .err0      (su_err0)
    );

    logic                      advance, last, step_minor;
    logic signed [COORD_W+1:0] err_sum, err_nxt;
    logic [COORD_W-1:0]        maj_nxt, mnr_nxt;

    always_comb begin
`ifdef LINE_PIXEL_STALL_EN
        advance = pixel_valid && pixel_ready;
`else
        advance = 1'b1;
`endif
        last    = (maj == maj_end);
        err_sum = err + {dy_r[COORD_W], dy_r};
        // A flat minor axis never steps; matters when the major span is 1 and err starts at 0.
        step_minor = !err_sum[COORD_W+1] && (dy_r != '0);
        err_nxt = step_minor ? err_sum - {dx_r[COORD_W], dx_r} : err_sum;
        mnr_nxt = step_minor ? (ystep_neg_r ? mnr - ONE : mnr + ONE) : mnr;
        maj_nxt = maj + ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= L_IDLE;
            x           <= '0;
            y           <= '0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ex0         <= '0;
            ey0         <= '0;
            ex1         <= '0;
            ey1         <= '0;
            steep_r     <= 1'b0;
            ystep_neg_r <= 1'b0;
            maj         <= '0;
            mnr         <= '0;
            maj_end     <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            err         <= '0;
        end else begin
            case (state)
                L_IDLE, L_DONE: begin
                    if (start) begin
                        ex0   <= x0;
                        ey0   <= y0;
                        ex1   <= x1;
                        ey1   <= y1;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= L_SETUP;
                    end
                end
                L_SETUP: begin
                    steep_r     <= su_steep;
                    ystep_neg_r <= su_neg;
                    maj         <= su_maj0;
                    mnr         <= su_mnr0;
                    maj_end     <= su_maj1;
                    dx_r        <= su_dx;
                    dy_r        <= su_dy;
                    err         <= su_err0;
                    x           <= su_steep ? su_mnr0 : su_maj0;
                    y           <= su_steep ? su_maj0 : su_mnr0;
                    pixel_valid <= 1'b1;
                    state       <= L_DRAW;
                end
                L_DRAW: begin
                    if (advance) begin
                        if (last) begin
                            pixel_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= L_DONE;
                        end else begin
                            maj <= maj_nxt;
                            mnr <= mnr_nxt;
                            err <= err_nxt;
                            x   <= steep_r ? mnr_nxt : maj_nxt;
                            y   <= steep_r ? maj_nxt : mnr_nxt;
                        end
                    end
                end
                default: state <= L_IDLE;
            endcase
        end
    end

endmodule
